flip_dispatch: RTL and testbench
================================

FLIP_DISPATCH -- requirements
Module: flip_dispatch

Interface
REQ-001 Parameter N, default 16: number of upstream accumulator lanes, one weight per lane, legal range 2..256.
REQ-002 Parameter IDX_W, default $clog2(N): width of the weight index.
REQ-003 Parameter INIT_W, default 0 (N bits): reset value of the weight vector.
REQ-004 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-low reset.
REQ-006 prop_in  input  1  backward-propagation phase enable; trig_in is ignored when low.
REQ-007 trig_in  input  N  one-cycle flip pulses, bit i from accumulator lane i.
REQ-008 clear_in  input  1  synchronous discard of all pending flips.
REQ-009 flip_valid_out  output  1  an offered flip index is valid.
REQ-010 flip_idx_out  output  IDX_W  index of the offered flip.
REQ-011 flip_ready_in  input  1  downstream accepts the offered flip.
REQ-012 weights_out  output  N  current binary weight vector, registered.
REQ-013 busy_out  output  1  high when any flip is pending or offered.
REQ-014 cancel_count_out  output  8  saturating count of cancelled flip pairs.

Function
REQ-015 Pending mask P (N bits), per cycle: P_next = (P & ~sel_onehot) ^ (prop_in ? trig_in : 0); when clear_in=1, P_next = 0 instead.
REQ-016 Trigger on a lane whose P bit is already set and is not being selected this cycle: bit clears, because two flips cancel; cancel_count_out increments by one per such lane per cycle and saturates at 255.
REQ-017 Trigger on the lane being selected in the same cycle: the selected flip proceeds and the P bit is set again as a new pending flip, not counted as a cancel.
REQ-018 FSM states: IDLE and OFFER.
REQ-019 IDLE, P != 0: select the first set bit of P at or after rr_ptr, wrapping modulo N; load flip_idx_out; set flip_valid_out=1; set rr_ptr = (idx+1) mod N; go to OFFER.
REQ-020 IDLE, P == 0: flip_valid_out=0 and the FSM stays in IDLE.
REQ-021 OFFER: flip_idx_out and flip_valid_out hold stable until flip_ready_in=1; the offer is never withdrawn, including under clear_in.
REQ-022 OFFER with flip_valid_out & flip_ready_in: weights_out[flip_idx_out] toggles on that edge, flip_valid_out drops, and the FSM returns to IDLE.
REQ-023 Throughput is at most one flip per 2 cycles.
REQ-024 Latency from trig_in to flip_valid_out, with IDLE and a sole pending lane: 2 cycles.
REQ-025 A trigger on the lane currently offered in OFFER sets its P bit as a new pending flip.
REQ-026 When rr_ptr reaches N-1, the next value wraps to 0.
REQ-027 Round-robin selection ensures no lane starves while triggers are continuous.
REQ-028 busy_out = (P != 0) | flip_valid_out, registered-equivalent with no combinational path from inputs.
REQ-029 clear_in does not reset cancel_count_out, rr_ptr or weights_out.

Reset
REQ-030 While rst_in=0, asynchronously: P=0, state=IDLE, flip_valid_out=0, flip_idx_out=0, rr_ptr=0, weights_out=INIT_W, cancel_count_out=0, busy_out=0.
REQ-031 Reset asserted mid-OFFER abandons the offer and does not toggle any weight.
REQ-032 Reset deassertion takes effect on the first rising edge after rst_in rises.

Verification
REQ-033 N=16, prop_in=1, trig_in=0x0004 for one cycle, ready held high -> flip_valid_out=1, flip_idx_out=2 two cycles later; on the accepting edge weights_out bit 2 toggles 0->1; busy_out then low.
REQ-034 trig_in=0x0004 at cycle t and again at t+1 while the lane is still pending, not yet selected -> no offer for lane 2, cancel_count_out=1, weights_out unchanged.
REQ-035 trig_in=0xFFFF for one cycle, ready=1 -> indices offered in order 0,1,...,15, one every 2 cycles; final weights_out=0xFFFF; rr_ptr back at 0.
REQ-036 Offer idx=5 with ready=0 for 10 cycles while clear_in pulses and trig_in=0x0020 arrives -> idx 5 held stable throughout; after acceptance lane 5 is re-offered exactly once; net weight bit 5 unchanged after both flips.
REQ-037 prop_in=0 with trig_in=0xFFFF -> P stays 0 and busy_out stays 0.
REQ-038 Cancel saturation: 300 cancel pairs -> cancel_count_out=255.
REQ-039 rst_in driven low mid-OFFER -> outputs immediately return to their reset values per REQ-030.

Source files
------------

// File: rtl/flip_dispatch.sv
// -----------------------------------------------------------------------------
// flip_dispatch
//
// Collects one-cycle weight-flip requests from N accumulator lanes during the
// backward-propagation phase and hands them out one at a time over a
// valid/ready channel. An accepted flip toggles the matching bit of the
// binary weight vector. Two requests on the same lane that both arrive before
// the lane is picked cancel each other, and the cancellation is counted.
//
// Ports
//   clk_in            single clock, rising edge
//   rst_in            asynchronous active-low reset
//   prop_in           backward-propagation enable; trig_in ignored when low
//   trig_in[N]        one-cycle flip pulses, bit i from lane i
//   clear_in          synchronous discard of all pending flips
//   flip_valid_out    an offered flip index is valid
//   flip_idx_out      index of the offered flip
//   flip_ready_in     downstream accepts the offered flip
//   weights_out[N]    current binary weight vector (registered)
//   busy_out          a flip is pending or offered (registered)
//   cancel_count_out  saturating count of cancelled flip pairs
// -----------------------------------------------------------------------------
module flip_dispatch #(
   parameter int             N      = 16,
   parameter int             IDX_W  = $clog2(N),
   parameter logic [N-1:0]   INIT_W = '0
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             prop_in,
   input  logic [N-1:0]     trig_in,
   input  logic             clear_in,
   output logic             flip_valid_out,
   output logic [IDX_W-1:0] flip_idx_out,
   input  logic             flip_ready_in,
   output logic [N-1:0]     weights_out,
   output logic             busy_out,
   output logic [7:0]       cancel_count_out
);

   // Wide enough to hold a popcount of all N lanes.
   localparam int CNT_W = $clog2(N + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   state_t             state_reg, state_next;
   logic [N-1:0]       pend_reg, pend_next;
   logic               valid_reg, valid_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic [IDX_W-1:0]   rr_reg, rr_next;
   logic [N-1:0]       weights_reg, weights_next;
   logic [7:0]         cnt_reg, cnt_next;
   logic               busy_reg, busy_next;

   logic [N-1:0]       trig_eff;
   logic [N-1:0]       sel_onehot;
   logic [N-1:0]       cancel_vec;
   logic               found;
   logic [IDX_W-1:0]   sel_idx;
   logic               take_sel;
   logic [CNT_W-1:0]   cancel_pop;
   logic [9:0]         cnt_sum;

   // ------------------------------------------------------------------
   // Round-robin search: first pending lane at or after rr_reg, wrapping.
   // ------------------------------------------------------------------
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      found    = 1'b0;
      sel_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < N; k++) begin
         cand = int'(rr_reg) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         cand_idx = IDX_W'(cand);
         if (!found && pend_reg[cand_idx]) begin
            found   = 1'b1;
            sel_idx = cand_idx;
         end
      end
   end

   // A selection is only made from IDLE; a clear in the same cycle wins so
   // that discarded flips are never offered.
   assign take_sel = (state_reg == IDLE) && found && !clear_in;

   assign trig_eff = prop_in ? trig_in : '0;

   // Per-lane selection mask and cancel detection. A trigger on the lane
   // being selected this cycle is a fresh request, not a cancellation.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         assign sel_onehot[gi] = take_sel && (sel_idx == IDX_W'(gi));
         assign cancel_vec[gi] = trig_eff[gi] & pend_reg[gi] & ~sel_onehot[gi];
      end
   endgenerate

   // Number of lanes cancelling in this cycle.
   always_comb begin
      cancel_pop = '0;
      for (int i = 0; i < N; i++) begin
         cancel_pop = cancel_pop + CNT_W'(cancel_vec[i]);
      end
   end

   // Saturating accumulate at 255.
   always_comb begin
      cnt_sum  = 10'(cnt_reg) + 10'(cancel_pop);
      cnt_next = (cnt_sum > 10'd255) ? 8'hFF : cnt_sum[7:0];
   end

   // Pending mask: XOR folds cancellation and re-arm into one expression.
   always_comb begin
      if (clear_in) begin
         pend_next = '0;
      end else begin
         pend_next = (pend_reg & ~sel_onehot) ^ trig_eff;
      end
   end

   // ------------------------------------------------------------------
   // Offer FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      valid_next   = valid_reg;
      idx_next     = idx_reg;
      rr_next      = rr_reg;
      weights_next = weights_reg;
      unique case (state_reg)
         IDLE: begin
            valid_next = 1'b0;
            if (take_sel) begin
               idx_next   = sel_idx;
               valid_next = 1'b1;
               rr_next    = (sel_idx == IDX_W'(N - 1)) ? '0 : sel_idx + IDX_W'(1);
               state_next = OFFER;
            end
         end
         OFFER: begin
            // The offer stays up until taken; clear_in does not withdraw it.
            if (flip_ready_in) begin
               weights_next[idx_reg] = ~weights_reg[idx_reg];
               valid_next            = 1'b0;
               state_next            = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            valid_next = 1'b0;
         end
      endcase
   end

   // busy is computed from next-state values so the output is a flop.
   assign busy_next = (|pend_next) | valid_next;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_reg   <= IDLE;
         pend_reg    <= '0;
         valid_reg   <= 1'b0;
         idx_reg     <= '0;
         rr_reg      <= '0;
         weights_reg <= INIT_W;
         cnt_reg     <= '0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pend_reg    <= pend_next;
         valid_reg   <= valid_next;
         idx_reg     <= idx_next;
         rr_reg      <= rr_next;
         weights_reg <= weights_next;
         cnt_reg     <= cnt_next;
         busy_reg    <= busy_next;
      end
   end

   assign flip_valid_out   = valid_reg;
   assign flip_idx_out     = idx_reg;
   assign weights_out      = weights_reg;
   assign busy_out         = busy_reg;
   assign cancel_count_out = cnt_reg;

endmodule

// File: tb/tb_flip_dispatch.sv
// -----------------------------------------------------------------------------
// tb_flip_dispatch
//
// Directed bench for flip_dispatch (N=16). Inputs are driven and outputs are
// sampled on the falling clock edge; every expected value is hand-derived.
// -----------------------------------------------------------------------------
module tb_flip_dispatch;

   localparam int N     = 16;
   localparam int IDX_W = 4;

   logic             clk_in;
   logic             rst_in;
   logic             prop_in;
   logic [N-1:0]     trig_in;
   logic             clear_in;
   logic             flip_valid_out;
   logic [IDX_W-1:0] flip_idx_out;
   logic             flip_ready_in;
   logic [N-1:0]     weights_out;
   logic             busy_out;
   logic [7:0]       cancel_count_out;

   int n_checks;
   int n_errors;

   flip_dispatch #(
      .N      (N),
      .IDX_W  (IDX_W),
      .INIT_W ('0)
   ) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .prop_in          (prop_in),
      .trig_in          (trig_in),
      .clear_in         (clear_in),
      .flip_valid_out   (flip_valid_out),
      .flip_idx_out     (flip_idx_out),
      .flip_ready_in    (flip_ready_in),
      .weights_out      (weights_out),
      .busy_out         (busy_out),
      .cancel_count_out (cancel_count_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and land on the following falling edge.
   task automatic step();
      @(negedge clk_in);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"},  32'(flip_valid_out),   32'd0);
      chk({tag, "_idx"},    32'(flip_idx_out),     32'd0);
      chk({tag, "_w"},      32'(weights_out),      32'd0);
      chk({tag, "_busy"},   32'(busy_out),         32'd0);
      chk({tag, "_cnt"},    32'(cancel_count_out), 32'd0);
   endtask

   initial begin
      logic [N-1:0] exp_w;
      n_checks      = 0;
      n_errors      = 0;
      rst_in        = 1'b0;
      prop_in       = 1'b0;
      trig_in       = '0;
      clear_in      = 1'b0;
      flip_ready_in = 1'b0;

      // ---------------- reset state ----------------
      step();
      step();
      check_reset_outputs("reset");
      rst_in = 1'b1;
      step();

      // ---------------- single flip, lane 2 ----------------
      prop_in       = 1'b1;
      flip_ready_in = 1'b1;
      trig_in       = 16'h0004;
      step();                                   // P = 0x0004
      trig_in = '0;
      chk("lat1_valid", 32'(flip_valid_out), 32'd0);
      chk("lat1_busy",  32'(busy_out),       32'd1);
      step();                                   // lane 2 offered
      chk("offer2_valid", 32'(flip_valid_out), 32'd1);
      chk("offer2_idx",   32'(flip_idx_out),   32'd2);
      chk("offer2_w",     32'(weights_out),    32'h0000);
      step();                                   // accepted
      chk("acc2_valid", 32'(flip_valid_out), 32'd0);
      chk("acc2_w",     32'(weights_out),    32'h0004);
      chk("acc2_busy",  32'(busy_out),       32'd0);

      // ---------------- cancel pair while lane 0 is offered ----------------
      flip_ready_in = 1'b0;
      trig_in       = 16'h0001;
      step();
      trig_in = '0;
      step();                                   // lane 0 offered, rr=1
      chk("hold0_valid", 32'(flip_valid_out), 32'd1);
      chk("hold0_idx",   32'(flip_idx_out),   32'd0);
      trig_in = 16'h0004;
      step();                                   // lane 2 pending
      trig_in = 16'h0004;
      step();                                   // lane 2 cancelled
      trig_in = '0;
      chk("cancel_cnt",  32'(cancel_count_out), 32'd1);
      chk("cancel_busy", 32'(busy_out),         32'd1);
      flip_ready_in = 1'b1;
      step();                                   // lane 0 accepted
      chk("cancel_acc_valid", 32'(flip_valid_out), 32'd0);
      chk("cancel_acc_w",     32'(weights_out),    32'h0005);
      chk("cancel_acc_busy",  32'(busy_out),       32'd0);
      step();
      step();
      chk("cancel_no_offer", 32'(flip_valid_out), 32'd0);
      chk("cancel_w_keep",   32'(weights_out),    32'h0005);

      // ---------------- held offer of lane 5 with clear and re-trigger ----------------
      flip_ready_in = 1'b0;
      trig_in       = 16'h0020;
      step();
      trig_in = '0;
      step();                                   // lane 5 offered, rr=6
      chk("hold5_start_idx", 32'(flip_idx_out), 32'd5);
      for (int i = 0; i < 10; i++) begin
         clear_in = (i == 1);
         trig_in  = (i == 3) ? 16'h0020 : 16'h0000;
         step();
         chk($sformatf("hold5_valid_%0d", i), 32'(flip_valid_out), 32'd1);
         chk($sformatf("hold5_idx_%0d", i),   32'(flip_idx_out),   32'd5);
      end
      clear_in      = 1'b0;
      trig_in       = '0;
      flip_ready_in = 1'b1;
      step();                                   // first flip of lane 5
      chk("re5_acc1_valid", 32'(flip_valid_out), 32'd0);
      chk("re5_acc1_w",     32'(weights_out),    32'h0025);
      chk("re5_acc1_busy",  32'(busy_out),       32'd1);
      step();                                   // lane 5 re-offered
      chk("re5_offer_valid", 32'(flip_valid_out), 32'd1);
      chk("re5_offer_idx",   32'(flip_idx_out),   32'd5);
      step();                                   // second flip of lane 5
      chk("re5_acc2_w",    32'(weights_out), 32'h0005);
      chk("re5_acc2_busy", 32'(busy_out),    32'd0);
      step();
      step();
      chk("re5_once", 32'(flip_valid_out), 32'd0);

      // ---------------- prop_in low ignores triggers ----------------
      prop_in = 1'b0;
      trig_in = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("noprop_busy_%0d", i),  32'(busy_out),       32'd0);
         chk($sformatf("noprop_valid_%0d", i), 32'(flip_valid_out), 32'd0);
      end
      trig_in = '0;
      prop_in = 1'b1;
      step();
      chk("noprop_after_busy", 32'(busy_out), 32'd0);

      // ---------------- asynchronous reset mid-offer ----------------
      flip_ready_in = 1'b0;
      trig_in       = 16'h0100;
      step();
      trig_in = '0;
      step();                                   // lane 8 offered
      chk("rst_pre_valid", 32'(flip_valid_out), 32'd1);
      chk("rst_pre_idx",   32'(flip_idx_out),   32'd8);
      rst_in = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      flip_ready_in = 1'b1;
      step();
      check_reset_outputs("rst_held");
      rst_in = 1'b1;
      step();
      step();
      chk("rst_after_valid", 32'(flip_valid_out), 32'd0);
      chk("rst_after_w",     32'(weights_out),    32'h0000);
      chk("rst_after_busy",  32'(busy_out),       32'd0);

      // ---------------- all lanes in round-robin order ----------------
      trig_in = 16'hFFFF;
      step();
      trig_in = '0;
      exp_w   = '0;
      for (int k = 0; k < N; k++) begin
         step();
         chk($sformatf("rr_valid_%0d", k), 32'(flip_valid_out), 32'd1);
         chk($sformatf("rr_idx_%0d", k),   32'(flip_idx_out),   32'(k));
         step();
         exp_w[k] = 1'b1;
         chk($sformatf("rr_gap_%0d", k), 32'(flip_valid_out), 32'd0);
         chk($sformatf("rr_w_%0d", k),   32'(weights_out),    32'(exp_w));
      end
      chk("rr_final_w",    32'(weights_out), 32'h0000FFFF);
      chk("rr_final_busy", 32'(busy_out),    32'd0);
      // Pointer wrapped to 0: lane 0 must win over lane 15.
      trig_in = 16'h8001;
      step();
      trig_in = '0;
      step();
      chk("wrap_first_idx", 32'(flip_idx_out), 32'd0);
      step();
      step();
      chk("wrap_second_idx", 32'(flip_idx_out), 32'd15);
      step();
      chk("wrap_w",    32'(weights_out), 32'h7FFE);
      chk("wrap_busy", 32'(busy_out),    32'd0);

      // ---------------- cancel saturation ----------------
      flip_ready_in = 1'b0;
      trig_in       = 16'h0001;
      step();
      trig_in = '0;
      step();                                   // lane 0 offered, holds FSM
      chk("sat_hold_idx", 32'(flip_idx_out), 32'd0);
      trig_in = 16'hFFFE;
      step();
      step();
      chk("sat_cnt_15", 32'(cancel_count_out), 32'd15);
      for (int i = 0; i < 18; i++) step();
      chk("sat_cnt_150", 32'(cancel_count_out), 32'd150);
      for (int i = 0; i < 20; i++) step();      // 20 pairs total = 300 cancels
      chk("sat_cnt_255", 32'(cancel_count_out), 32'd255);
      step();
      step();
      chk("sat_cnt_hold", 32'(cancel_count_out), 32'd255);
      trig_in       = '0;
      flip_ready_in = 1'b1;
      step();
      chk("sat_acc_w",    32'(weights_out), 32'h7FFF);
      chk("sat_acc_busy", 32'(busy_out),    32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
